// File: rtl/approx_err_accum.sv
// Windowed error statistics (count, sum |e|, sum e^2) of an approximate adder against the exact sum.
// Optional peak-error capture (max_abs, max_a, max_b) is enabled by defining APPROX_ERR_MAX_EN.
module approx_err_accum #(
    parameter int WIDTH  = 16,
    parameter int N_LOG2 = 10,
    parameter int ACC_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH:0]     in_approx,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_LOG2:0]    err_cnt,
    output logic [ACC_W-1:0]   sum_abs,
    output logic [ACC_W-1:0]   sum_sq,
    output logic               busy
`ifdef APPROX_ERR_MAX_EN
    ,
    output logic [WIDTH:0]     max_abs,
    output logic [WIDTH-1:0]   max_a,
    output logic [WIDTH-1:0]   max_b
`endif
);

    localparam int SQ_W  = 2 * (WIDTH + 1);
    // One bit wider than either operand of the saturating add so a carry-out is always visible.
    localparam int EXT_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam logic [N_LOG2:0] CNT_LAST = {1'b0, {N_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               in_ready_r, busy_r, res_valid_r;
    logic               in_ready_nxt_s, busy_nxt_s, res_valid_nxt_s;
    logic [N_LOG2:0]    cnt_r;
    logic               win_start_s, accept_s, last_s;
    logic [WIDTH:0]     exact_s;
    logic [WIDTH+1:0]   err_s, neg_s;
    logic [WIDTH:0]     abs_s;
    logic               s1_valid_r, s1_nz_r, s2_valid_r;
    logic [WIDTH:0]     s1_abs_r;
    logic [SQ_W-1:0]    sq_s;
    logic [N_LOG2:0]    err_cnt_r;
    logic [ACC_W-1:0]   sum_abs_r, sum_sq_r;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [EXT_W-1:0] inc);
        logic [EXT_W-1:0] total;
        total = {{(EXT_W-ACC_W){1'b0}}, acc} + inc;
        if (total > {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}}) begin
            sat_add = {ACC_W{1'b1}};
        end else begin
            sat_add = total[ACC_W-1:0];
        end
    endfunction

    assign win_start_s = (state_r == ST_IDLE) && start;
    assign accept_s    = (state_r == ST_RUN) && in_valid && in_ready_r;
    assign last_s      = (cnt_r == CNT_LAST);

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            res_valid_r <= res_valid_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && last_s) state_nxt_s = ST_DRAIN;
                else                    state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!s1_valid_r && !s2_valid_r) state_nxt_s = ST_DONE;
                else                            state_nxt_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (res_valid_r && res_ready) state_nxt_s = ST_IDLE;
                else                          state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control outputs follow the state being entered so they are registered yet cycle-aligned.
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == ST_RUN);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        res_valid_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Sample counter for the current window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {(N_LOG2+1){1'b0}};
        end else if (win_start_s) begin
            cnt_r <= {(N_LOG2+1){1'b0}};
        end else if (accept_s) begin
            cnt_r <= cnt_r + {{N_LOG2{1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Signed error and its magnitude; the magnitude always fits in WIDTH+1 bits.
    always_comb begin
        exact_s = {1'b0, in_a} + {1'b0, in_b};
        err_s   = {1'b0, in_approx} - {1'b0, exact_s};
        neg_s   = (~err_s) + {{(WIDTH+1){1'b0}}, 1'b1};
        if (err_s[WIDTH+1]) abs_s = neg_s[WIDTH:0];
        else                abs_s = err_s[WIDTH:0];
        sq_s = {{(WIDTH+1){1'b0}}, s1_abs_r} * {{(WIDTH+1){1'b0}}, s1_abs_r};
    end

    // Stage 1: register error magnitude and nonzero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_abs_r   <= {(WIDTH+1){1'b0}};
            s1_nz_r    <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_abs_r <= abs_s;
                s1_nz_r  <= (err_s != {(WIDTH+2){1'b0}});
            end else begin
                s1_abs_r <= s1_abs_r;
                s1_nz_r  <= s1_nz_r;
            end
        end
    end

    // Stage 2: saturating accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            err_cnt_r  <= {(N_LOG2+1){1'b0}};
            sum_abs_r  <= {ACC_W{1'b0}};
            sum_sq_r   <= {ACC_W{1'b0}};
        end else if (win_start_s) begin
            s2_valid_r <= 1'b0;
            err_cnt_r  <= {(N_LOG2+1){1'b0}};
            sum_abs_r  <= {ACC_W{1'b0}};
            sum_sq_r   <= {ACC_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                err_cnt_r <= err_cnt_r + {{N_LOG2{1'b0}}, s1_nz_r};
                sum_abs_r <= sat_add(sum_abs_r, {{(EXT_W-WIDTH-1){1'b0}}, s1_abs_r});
                sum_sq_r  <= sat_add(sum_sq_r, {{(EXT_W-SQ_W){1'b0}}, sq_s});
            end else begin
                err_cnt_r <= err_cnt_r;
                sum_abs_r <= sum_abs_r;
                sum_sq_r  <= sum_sq_r;
            end
        end
    end

`ifdef APPROX_ERR_MAX_EN
    logic [WIDTH-1:0] s1_a_r, s1_b_r;
    logic [WIDTH:0]   max_abs_r;
    logic [WIDTH-1:0] max_a_r, max_b_r;

    // Operands travel with the error so the peak can be attributed to its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_r <= {WIDTH{1'b0}};
            s1_b_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_a_r <= in_a;
            s1_b_r <= in_b;
        end else begin
            s1_a_r <= s1_a_r;
            s1_b_r <= s1_b_r;
        end
    end

    // Peak tracker; strict compare keeps the earliest sample on ties.
    always_ff @(posedge clk) begin
        if (rst || win_start_s) begin
            max_abs_r <= {(WIDTH+1){1'b0}};
            max_a_r   <= {WIDTH{1'b0}};
            max_b_r   <= {WIDTH{1'b0}};
        end else if (s1_valid_r && (s1_abs_r > max_abs_r)) begin
            max_abs_r <= s1_abs_r;
            max_a_r   <= s1_a_r;
            max_b_r   <= s1_b_r;
        end else begin
            max_abs_r <= max_abs_r;
            max_a_r   <= max_a_r;
            max_b_r   <= max_b_r;
        end
    end

    assign max_abs = max_abs_r;
    assign max_a   = max_a_r;
    assign max_b   = max_b_r;
`else
    // Peak tracking not built.
`endif

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign err_cnt   = err_cnt_r;
    assign sum_abs   = sum_abs_r;
    assign sum_sq    = sum_sq_r;

endmodule
